// File: rtl/mine_mem_arbiter.sv
// mine_mem_arbiter
// Arbitrates a single-port 1-bit mine memory between three requesters and
// runs a full clear sweep on request.
//   clk, rst (async, active low)
//   clr_start / clr_done / busy : clear sweep request, completion pulse, activity
//   p_*   : placer writes, strict priority
//   r_*   : reveal reads/writes, round-robin with display
//   d_*   : display reads, round-robin with reveal
//   x_gnt : registered grant pulses, one cycle after the request is sampled
//   x_rdata / x_rvalid : read return, two cycles after the grant
//   mem_addr / mem_din / mem_wren : registered memory drive; mem_q : read data
module mine_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    output logic              clr_done,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic              p_din,
    input  logic              r_req,
    input  logic              r_we,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              r_din,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              p_gnt,
    output logic              r_gnt,
    output logic              d_gnt,
    output logic              r_rdata,
    output logic              r_rvalid,
    output logic              d_rdata,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_din,
    output logic              mem_wren,
    input  logic              mem_q,
    output logic              busy
);

    // state | meaning
    // IDLE  | arbitrate p / r / d requests
    // CLEAR | write 0 to one address per cycle, no grants
    // CDONE | single cycle, clr_done asserted
    typedef enum logic [1:0] {IDLE, CLEAR, CDONE} state_t;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    // Holds the next sweep address; one extra bit so DEPTH = 2^ADDR_W is reachable.
    logic [ADDR_W:0]   cnt_q, cnt_d;
    // 1 when d was served last, so r wins the next tie.
    logic              rr_last_d_q, rr_last_d_d;

    logic              p_g, r_g, d_g;
    logic [ADDR_W-1:0] addr_d;
    logic              din_d, wren_d;
    logic              rd_v, rd_id;

    // Tag pipeline: stage 0 lines up with the memory address cycle,
    // stage 1 with the cycle mem_q is valid. id 0 = reveal, 1 = display.
    logic              t0_v, t0_id, t1_v, t1_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_last_d_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_last_d_q <= rr_last_d_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_last_d_d = rr_last_d_q;
        p_g         = 1'b0;
        r_g         = 1'b0;
        d_g         = 1'b0;
        addr_d      = '0;
        din_d       = 1'b0;
        wren_d      = 1'b0;
        rd_v        = 1'b0;
        rd_id       = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    wren_d  = 1'b1;
                    cnt_d   = (ADDR_W + 1)'(1);
                end else if (p_req) begin
                    p_g    = 1'b1;
                    addr_d = p_addr;
                    din_d  = p_din;
                    wren_d = 1'b1;
                end else if (r_req && (!d_req || rr_last_d_q)) begin
                    r_g         = 1'b1;
                    addr_d      = r_addr;
                    din_d       = r_we & r_din;
                    wren_d      = r_we;
                    rd_v        = !r_we;
                    rd_id       = 1'b0;
                    rr_last_d_d = 1'b0;
                end else if (d_req) begin
                    d_g         = 1'b1;
                    addr_d      = d_addr;
                    rd_v        = 1'b1;
                    rd_id       = 1'b1;
                    rr_last_d_d = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = CDONE;
                end else begin
                    addr_d = cnt_q[ADDR_W-1:0];
                    wren_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            CDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_gnt    <= 1'b0;
            r_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 1'b0;
            mem_wren <= 1'b0;
            t0_v     <= 1'b0;
            t0_id    <= 1'b0;
            t1_v     <= 1'b0;
            t1_id    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= 1'b0;
        end else begin
            p_gnt    <= p_g;
            r_gnt    <= r_g;
            d_gnt    <= d_g;
            mem_addr <= addr_d;
            mem_din  <= din_d;
            mem_wren <= wren_d;
            t0_v     <= rd_v;
            t0_id    <= rd_id;
            t1_v     <= t0_v;
            t1_id    <= t0_id;
            r_rvalid <= t1_v && !t1_id;
            d_rvalid <= t1_v && t1_id;
            if (t1_v && !t1_id) r_rdata <= mem_q;
            if (t1_v && t1_id)  d_rdata <= mem_q;
        end
    end

    assign busy     = (state_q != IDLE);
    assign clr_done = (state_q == CDONE);

endmodule

// File: tb/tb_mine_mem_arbiter.sv
module tb_mine_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_start, clr_done;
    logic       p_req, p_din, r_req, r_we, r_din, d_req;
    logic [7:0] p_addr, r_addr, d_addr, mem_addr;
    logic       p_gnt, r_gnt, d_gnt;
    logic       r_rdata, r_rvalid, d_rdata, d_rvalid;
    logic       mem_din, mem_wren, busy;
    logic       mem_q = 1'b0;
    logic [255:0] mem = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sweep_exp = 0;
    int sweep_n = 0;

    typedef struct {
        int         id;   // 0 p, 1 r, 2 d
        logic [7:0] addr;
        logic       we;
        logic       din;
    } gnt_t;
    typedef struct {
        int   id;         // 1 r, 2 d
        logic data;
    } rd_t;

    gnt_t exp_g[$];
    rd_t  exp_r[$];
    int   rd_cyc[$];

    mine_mem_arbiter #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .clr_start(clr_start), .clr_done(clr_done),
        .p_req(p_req), .p_addr(p_addr), .p_din(p_din),
        .r_req(r_req), .r_we(r_we), .r_addr(r_addr), .r_din(r_din),
        .d_req(d_req), .d_addr(d_addr),
        .p_gnt(p_gnt), .r_gnt(r_gnt), .d_gnt(d_gnt),
        .r_rdata(r_rdata), .r_rvalid(r_rvalid), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren),
        .mem_q(mem_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous 1-bit memory, read-before-write.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mem_q <= mem[mem_addr];
        if (mem_wren) mem[mem_addr] <= mem_din;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic gnt_t mk_g(int id, logic [7:0] a, logic we, logic din);
        gnt_t g;
        g.id = id; g.addr = a; g.we = we; g.din = din;
        return g;
    endfunction

    function automatic rd_t mk_r(int id, logic d);
        rd_t r;
        r.id = id; r.data = d;
        return r;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a grant or read return.
    always @(negedge clk) begin
        if (rst) begin
            if (p_gnt | r_gnt | d_gnt) begin
                gnt_t e;
                int   id;
                check("gnt_onehot", $countones({p_gnt, r_gnt, d_gnt}), 1);
                check("gnt_while_busy", busy, 0);
                id = p_gnt ? 0 : (r_gnt ? 1 : 2);
                if (exp_g.size() == 0) begin
                    check("gnt_unexpected", id, 99);
                end else begin
                    e = exp_g.pop_front();
                    check("gnt_id", id, e.id);
                    check("gnt_addr", mem_addr, e.addr);
                    check("gnt_we", mem_wren, e.we);
                    if (e.we) check("gnt_din", mem_din, e.din);
                    if (!mem_wren) rd_cyc.push_back(cyc);
                end
            end
            if (busy && mem_wren) begin
                check("sweep_addr", mem_addr, sweep_exp[7:0]);
                check("sweep_din", mem_din, 0);
                sweep_exp++;
                sweep_n++;
            end
            if (r_rvalid | d_rvalid) begin
                rd_t e;
                check("rvalid_onehot", {r_rvalid, d_rvalid} == 2'b11, 0);
                if (exp_r.size() == 0 || rd_cyc.size() == 0) begin
                    check("rvalid_unexpected", r_rvalid ? 1 : 2, 99);
                end else begin
                    e = exp_r.pop_front();
                    check("rd_id", r_rvalid ? 1 : 2, e.id);
                    check("rd_data", r_rvalid ? r_rdata : d_rdata, e.data);
                    check("rd_latency", cyc, rd_cyc.pop_front() + 2);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0; clr_start = 0;
        p_req = 0; p_addr = 0; p_din = 0;
        r_req = 0; r_we = 0; r_addr = 0; r_din = 0;
        d_req = 0; d_addr = 0;
        repeat (3) @(negedge clk);
        check("reset_outs", {p_gnt, r_gnt, d_gnt, r_rvalid, d_rvalid, r_rdata, d_rdata,
                             mem_wren, mem_din, clr_done, busy}, 0);
        check("reset_addr", mem_addr, 0);
        rst = 1'b1;
        @(negedge clk);

        // Priority and round robin: p first, then r (reset favour), d, r.
        exp_g.push_back(mk_g(0, 8'h07, 1, 1));
        exp_g.push_back(mk_g(1, 8'h05, 1, 1));
        exp_g.push_back(mk_g(2, 8'h07, 0, 0));
        exp_g.push_back(mk_g(1, 8'h05, 1, 1));
        exp_r.push_back(mk_r(2, 1));
        p_req = 1; p_addr = 8'h07; p_din = 1;
        r_req = 1; r_we = 1; r_addr = 8'h05; r_din = 1;
        d_req = 1; d_addr = 8'h07;
        @(negedge clk); check("prio_p", p_gnt, 1); p_req = 0;
        @(negedge clk); check("prio_r1", r_gnt, 1);
        @(negedge clk); check("prio_d", d_gnt, 1);
        @(negedge clk); check("prio_r2", r_gnt, 1);
        r_req = 0; d_req = 0; r_we = 0; r_din = 0;
        repeat (4) @(negedge clk);

        // Clear sweep with simultaneous placer request.
        sweep_exp = 0; sweep_n = 0;
        exp_g.push_back(mk_g(0, 8'h2A, 1, 1));
        clr_start = 1; p_req = 1; p_addr = 8'h2A; p_din = 1;
        @(negedge clk);
        clr_start = 0;
        check("sweep_busy_first", busy, 1);
        n = 0;
        while (!clr_done && n < 300) begin @(negedge clk); n++; end
        check("clr_done_seen", clr_done, 1);
        check("busy_in_cdone", busy, 1);
        check("sweep_len", sweep_n, 256);
        check("p_withheld", p_gnt, 0);
        @(negedge clk);
        check("clr_done_pulse", clr_done, 0);
        check("busy_after", busy, 0);
        n = 0;
        while (!p_gnt && n < 10) begin @(negedge clk); n++; end
        check("p_after_clear", p_gnt, 1);
        p_req = 0;
        @(negedge clk);

        // Read latency on display.
        exp_g.push_back(mk_g(2, 8'h2A, 0, 0));
        exp_r.push_back(mk_r(2, 1));
        d_req = 1; d_addr = 8'h2A;
        @(negedge clk);
        check("lat_gnt", d_gnt, 1);
        check("lat_addr", mem_addr, 8'h2A);
        check("lat_wren", mem_wren, 0);
        d_req = 0;
        @(negedge clk); check("lat_early", d_rvalid, 0);
        @(negedge clk); check("lat_rvalid", d_rvalid, 1); check("lat_rdata", d_rdata, 1);
        @(negedge clk); check("lat_pulse", d_rvalid, 0);

        // Back-to-back reads, r favoured since d was last served.
        exp_g.push_back(mk_g(1, 8'h2A, 0, 0));
        exp_g.push_back(mk_g(2, 8'h05, 0, 0));
        exp_r.push_back(mk_r(1, 1));
        exp_r.push_back(mk_r(2, 0));
        r_req = 1; r_we = 0; r_addr = 8'h2A; d_req = 1; d_addr = 8'h05;
        @(negedge clk); check("ord_r_gnt", r_gnt, 1); r_req = 0;
        @(negedge clk); check("ord_d_gnt", d_gnt, 1); d_req = 0;
        @(negedge clk); check("ord_r_rvalid", r_rvalid, 1); check("ord_r_rdata", r_rdata, 1);
        @(negedge clk); check("ord_d_rvalid", d_rvalid, 1); check("ord_d_rdata", d_rdata, 0);
        repeat (2) @(negedge clk);

        // Reset abort at sweep address 100.
        clr_start = 1;
        @(negedge clk);
        clr_start = 0;
        n = 0;
        while (!(busy && mem_wren && mem_addr == 8'd100) && n < 200) begin @(negedge clk); n++; end
        check("abort_reached", mem_addr, 8'd100);
        rst = 1'b0;
        #1;
        check("abort_outs", {p_gnt, r_gnt, d_gnt, r_rvalid, d_rvalid, r_rdata, d_rdata,
                             mem_wren, mem_din, clr_done, busy}, 0);
        check("abort_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (clr_done || busy) n++;
        end
        check("abort_no_done", n, 0);

        check("gnt_queue_empty", exp_g.size(), 0);
        check("rd_queue_empty", exp_r.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mine_mem_arbiter.md
MINE_MEM_ARBITER -- requirements
Module: mine_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, address width of the 1-bit mine memory.
REQ-002 Parameter DEPTH, default 256, number of memory locations cleared by a sweep.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1: asynchronous active-low reset.
REQ-006 Port clr_start, input, 1: pulse that requests a full clear sweep.
REQ-007 Port clr_done, output, 1: one-cycle pulse when the clear sweep has finished.
REQ-008 Ports p_req, p_addr[ADDR_W], p_din, input: placer write request, priority 1.
REQ-009 Ports r_req, r_we, r_addr[ADDR_W], r_din, input: reveal read/write request, round-robin class.
REQ-010 Ports d_req, d_addr[ADDR_W], input: display read request, round-robin class.
REQ-011 Ports p_gnt, r_gnt, d_gnt, output, 1 each: registered grant pulses.
REQ-012 Ports r_rdata, r_rvalid, d_rdata, d_rvalid, output, 1 each: read return data and its valid flag.
REQ-013 Ports mem_addr[ADDR_W], mem_din, mem_wren, output: registered memory drive.
REQ-014 Port mem_q, input, 1: memory read data, valid the cycle after the memory samples the address.
REQ-015 Port busy, output, 1: high while a clear sweep is active.

Function
REQ-016 State machine states SHALL be IDLE (arbitrate), CLEAR (sweep), and CDONE (one cycle).
REQ-017 In IDLE, clr_start=1 SHALL move the FSM to CLEAR, and clr_start SHALL win over every request that cycle.
REQ-018 In CLEAR, the block SHALL write 0 to addresses 0..DEPTH-1, one address per cycle in ascending order, with mem_wren=1, and SHALL issue no grants.
REQ-019 After the write to DEPTH-1, the FSM SHALL go to CDONE, pulse clr_done for exactly 1 cycle, and then return to IDLE.
REQ-020 clr_start SHALL be ignored in CLEAR and CDONE.
REQ-021 busy SHALL be 1 in CLEAR and CDONE and 0 otherwise.
REQ-022 In IDLE, at most one grant SHALL issue per cycle; p_req SHALL have strict priority over r_req and d_req.
REQ-023 Between r_req and d_req, ownership SHALL alternate round-robin; the last-served pointer SHALL update only on an r or d grant.
REQ-024 After reset, the pointer SHALL favour r.
REQ-025 A grant decided from requests sampled in cycle T SHALL appear as x_gnt=1 in cycle T+1.
REQ-026 mem_addr, mem_din and mem_wren SHALL carry the granted access in the same cycle T+1.
REQ-027 mem_wren SHALL be 0 in any cycle without a write grant or sweep write.
REQ-028 A requester SHALL hold req and its operands stable until it sees gnt.
REQ-029 A requester that still has req=1 in the cycle gnt is seen SHALL have that cycle counted as a new request.
REQ-030 For a read granted in cycle G, the block SHALL register mem_q and assert the requester's rvalid with rdata in cycle G+2, for exactly 1 cycle.
REQ-031 Read returns SHALL be tracked by a 2-stage tag pipeline (valid, requester id), so back-to-back reads return in grant order.
REQ-032 A write access SHALL produce no rvalid.
REQ-033 mem_addr SHALL wrap naturally at 2^ADDR_W; addresses at or above DEPTH are passed through unchanged.
REQ-034 The sweep counter SHALL be ADDR_W+1 bits so that DEPTH=2^ADDR_W terminates correctly.

Reset
REQ-035 While rst=0, the FSM SHALL be IDLE, the pointer SHALL favour r, and the tag pipeline SHALL be cleared.
REQ-036 While rst=0, all gnt, rvalid, rdata, mem_wren, mem_din, mem_addr, clr_done and busy outputs SHALL be 0.
REQ-037 A reset asserted mid-sweep or mid-read SHALL abort the operation, and no pending rvalid or clr_done SHALL appear afterwards.

Verification
REQ-038 Clear sweep: pulse clr_start -> 256 consecutive cycles with mem_wren=1, mem_din=0, and mem_addr running 0..255; then clr_done=1 for 1 cycle; busy high from the first sweep cycle through CDONE.
REQ-039 Priority: p_req, r_req and d_req all held high -> p_gnt first; then r_gnt and d_gnt alternate while both stay asserted.
REQ-040 Read latency: d_req with d_addr=8'h2A, where memory holds 1 -> d_gnt in cycle T+1, mem_addr=8'h2A, mem_wren=0; d_rvalid=1 and d_rdata=1 in cycle T+3.
REQ-041 Read ordering: back-to-back r and d reads -> r_rvalid and d_rvalid on consecutive cycles, in grant order, with correct data.
REQ-042 Clear precedence: clr_start and p_req asserted in the same cycle -> sweep runs, p_gnt is withheld until CDONE, then p is granted.
REQ-043 Reset abort: rst dropped at sweep address 100 -> all outputs 0 at once; after release, FSM is IDLE and no clr_done appears.
